// File: rtl/ascon_ctrl_pkg.sv
// rtl/ascon_ctrl_pkg.sv - shared state encoding and block constants for the Ascon stream sequencer
package ascon_ctrl_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_AD,
    SEQ_MSG,
    SEQ_WAIT_TAG
  } seq_state_t;

  localparam int BLK_BYTES = 16;
  localparam int BLK_SHIFT = 4;
  localparam int VB_WIDTH  = 5;

endpackage

// File: rtl/ascon_blk_index.sv
// rtl/ascon_blk_index.sv - maps (byte length, block index) to last flag, valid byte count and block count
module ascon_blk_index
  import ascon_ctrl_pkg::*;
#(
  parameter int pLEN_WIDTH = 7,
  parameter int pIDX_WIDTH = 2,
  parameter int pCNT_WIDTH = 3
) (
  input  logic [pLEN_WIDTH-1:0] i_len,
  input  logic [pIDX_WIDTH-1:0] i_idx,
  output logic                  o_last,
  output logic [VB_WIDTH-1:0]   o_valid_bytes,
  output logic [pCNT_WIDTH-1:0] o_nblk
);

  localparam int LW1 = pLEN_WIDTH + 1;

  logic [LW1-1:0] w_len;
  logic [LW1-1:0] w_ceil;
  logic [LW1-1:0] w_nblk;
  logic [LW1-1:0] w_tail;

  // An empty phase still sends one block so the core sees a last_block with zero bytes.
  always_comb begin
    w_len         = LW1'(i_len);
    w_ceil        = (w_len + LW1'(BLK_BYTES - 1)) >> BLK_SHIFT;
    w_nblk        = (w_ceil == '0) ? LW1'(1) : w_ceil;
    w_tail        = w_len - ((w_nblk - LW1'(1)) << BLK_SHIFT);
    o_last        = (LW1'(i_idx) == (w_nblk - LW1'(1)));
    o_valid_bytes = o_last ? VB_WIDTH'(w_tail) : VB_WIDTH'(BLK_BYTES);
    o_nblk        = pCNT_WIDTH'(w_nblk);
  end

endmodule

// File: rtl/ascon_stream_sequencer.sv
// rtl/ascon_stream_sequencer.sv - feeds AD/PT blocks to ascon_top and collects ciphertext and tag
module ascon_stream_sequencer
  import ascon_ctrl_pkg::*;
#(
  parameter int pBLK_WIDTH = 128,
  parameter int pMAX_BLKS  = 4,
  parameter int pLEN_WIDTH = 7,
  parameter int pTIMEOUT   = 4096
) (
  input  logic                            crypto_clk,
  input  logic                            reset_i,
  input  logic                            I_start,
  input  logic [pLEN_WIDTH-1:0]           I_ad_len,
  input  logic [pLEN_WIDTH-1:0]           I_msg_len,
  input  logic [pMAX_BLKS*pBLK_WIDTH-1:0] I_ad_buf,
  input  logic [pMAX_BLKS*pBLK_WIDTH-1:0] I_msg_buf,
  input  logic                            I_read_data,
  input  logic                            I_ready_for_data,
  input  logic                            I_ct_valid,
  input  logic [pBLK_WIDTH-1:0]           I_ct,
  input  logic                            I_ready_tag,
  input  logic [pBLK_WIDTH-1:0]           I_tag,
  output logic                            O_key_valid,
  output logic [pBLK_WIDTH-1:0]           O_data,
  output logic                            O_valid_data,
  output logic                            O_last_block,
  output logic [VB_WIDTH-1:0]             O_valid_bytes,
  output logic                            O_eot,
  output logic [pMAX_BLKS*pBLK_WIDTH-1:0] O_ct_buf,
  output logic [pBLK_WIDTH-1:0]           O_tag,
  output logic                            O_busy,
  output logic                            O_done,
  output logic                            O_error
);

  localparam int IDX_W = $clog2(pMAX_BLKS);
  localparam int CNT_W = $clog2(pMAX_BLKS + 1);
  localparam int WD_W  = $clog2(pTIMEOUT);
  localparam logic [pLEN_WIDTH-1:0] MAX_LEN = pLEN_WIDTH'(pMAX_BLKS * BLK_BYTES);

  seq_state_t                      r_state;
  seq_state_t                      w_next_state;
  logic [pLEN_WIDTH-1:0]           r_ad_len;
  logic [pLEN_WIDTH-1:0]           r_msg_len;
  logic [IDX_W-1:0]                r_blk_idx;
  logic [CNT_W-1:0]                r_ct_idx;
  logic [WD_W-1:0]                 r_wdog;
  logic [pMAX_BLKS*pBLK_WIDTH-1:0] r_ct_buf;
  logic [pBLK_WIDTH-1:0]           r_tag;
  logic                            r_done;
  logic                            r_error;

  logic [pLEN_WIDTH-1:0] w_len_sel;
  logic                  w_last;
  logic [VB_WIDTH-1:0]   w_vb;
  logic [CNT_W-1:0]      w_nblk;
  logic                  w_busy;
  logic                  w_in_data;
  logic                  w_ct_phase;
  logic                  w_ct_wr;
  logic                  w_ct_ovf;
  logic [CNT_W-1:0]      w_ct_cnt;
  logic                  w_activity;
  logic                  w_timeout;
  logic                  w_accept;
  logic                  w_start_err;
  logic                  w_tag_ok;
  logic                  w_tag_bad;
  logic                  w_unused;

  // The read_data pulse is the only handshake needed; core idle status is informational.
  assign w_unused = I_ready_for_data;

  assign w_len_sel = (r_state == SEQ_AD) ? r_ad_len : r_msg_len;

  ascon_blk_index #(
    .pLEN_WIDTH (pLEN_WIDTH),
    .pIDX_WIDTH (IDX_W),
    .pCNT_WIDTH (CNT_W)
  ) u_blk_index (
    .i_len         (w_len_sel),
    .i_idx         (r_blk_idx),
    .o_last        (w_last),
    .o_valid_bytes (w_vb),
    .o_nblk        (w_nblk)
  );

  assign w_busy     = (r_state != SEQ_IDLE);
  assign w_in_data  = (r_state == SEQ_AD) || (r_state == SEQ_MSG);
  assign w_ct_phase = (r_state == SEQ_MSG) || (r_state == SEQ_WAIT_TAG);
  assign w_ct_wr    = w_ct_phase && I_ct_valid && (r_ct_idx < CNT_W'(pMAX_BLKS));
  assign w_ct_ovf   = w_ct_phase && I_ct_valid && (r_ct_idx >= CNT_W'(pMAX_BLKS));
  // A ciphertext block arriving alongside the tag still counts toward completeness.
  assign w_ct_cnt   = r_ct_idx + CNT_W'(w_ct_wr);
  assign w_activity = I_read_data || I_ct_valid || I_ready_tag;
  assign w_timeout  = w_busy && !w_activity && (r_wdog == WD_W'(pTIMEOUT - 1));

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_start_err  = 1'b0;
    w_tag_ok     = 1'b0;
    w_tag_bad    = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (I_start) begin
          if ((I_ad_len > MAX_LEN) || (I_msg_len > MAX_LEN)) begin
            w_start_err = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_next_state = SEQ_AD;
          end
        end
      end
      SEQ_AD: begin
        if (I_read_data && w_last) w_next_state = SEQ_MSG;
      end
      SEQ_MSG: begin
        if (I_read_data && w_last) w_next_state = SEQ_WAIT_TAG;
      end
      SEQ_WAIT_TAG: begin
        if (I_ready_tag) begin
          if (w_ct_cnt == w_nblk) w_tag_ok = 1'b1;
          else                    w_tag_bad = 1'b1;
          w_next_state = SEQ_IDLE;
        end
      end
      default: w_next_state = SEQ_IDLE;
    endcase
    if (w_timeout) w_next_state = SEQ_IDLE;
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) r_state <= SEQ_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      r_ad_len  <= '0;
      r_msg_len <= '0;
      r_blk_idx <= '0;
      r_ct_idx  <= '0;
      r_wdog    <= '0;
      r_ct_buf  <= '0;
      r_tag     <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done <= w_tag_ok;
      if (!w_busy || w_activity) r_wdog <= '0;
      else                       r_wdog <= r_wdog + WD_W'(1);
      if (w_accept) begin
        r_ad_len  <= I_ad_len;
        r_msg_len <= I_msg_len;
        r_blk_idx <= '0;
        r_ct_idx  <= '0;
        r_ct_buf  <= '0;
        r_error   <= 1'b0;
      end else begin
        if (w_in_data && I_read_data) begin
          r_blk_idx <= w_last ? '0 : r_blk_idx + IDX_W'(1);
        end
        if (w_ct_wr) begin
          r_ct_buf[r_ct_idx[IDX_W-1:0]*pBLK_WIDTH +: pBLK_WIDTH] <= I_ct;
          r_ct_idx <= r_ct_idx + CNT_W'(1);
        end
        if ((r_state == SEQ_WAIT_TAG) && I_ready_tag) r_tag <= I_tag;
        if (w_start_err || w_ct_ovf || w_tag_bad || w_timeout) r_error <= 1'b1;
      end
    end
  end

  assign O_key_valid   = w_busy;
  assign O_valid_data  = w_in_data;
  assign O_eot         = (r_state == SEQ_MSG);
  assign O_last_block  = w_in_data && w_last;
  assign O_valid_bytes = w_in_data ? w_vb : '0;
  assign O_data        = (r_state == SEQ_AD)  ? I_ad_buf[r_blk_idx*pBLK_WIDTH +: pBLK_WIDTH]  :
                         (r_state == SEQ_MSG) ? I_msg_buf[r_blk_idx*pBLK_WIDTH +: pBLK_WIDTH] :
                                                '0;
  assign O_ct_buf      = r_ct_buf;
  assign O_tag         = r_tag;
  assign O_busy        = w_busy;
  assign O_done        = r_done;
  assign O_error       = r_error;

endmodule

// File: tb/tb_ascon_stream_sequencer.sv
// tb/tb_ascon_stream_sequencer.sv - scoreboard bench for ascon_stream_sequencer with a reactive core model
module tb_ascon_stream_sequencer;

  localparam int TO = 4096;
  localparam logic [127:0] CT_MASK = 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;

  logic         crypto_clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         I_start = 1'b0;
  logic [6:0]   I_ad_len = '0;
  logic [6:0]   I_msg_len = '0;
  logic [511:0] I_ad_buf;
  logic [511:0] I_msg_buf;
  logic         I_read_data = 1'b0;
  logic         I_ready_for_data = 1'b1;
  logic         I_ct_valid = 1'b0;
  logic [127:0] I_ct = '0;
  logic         I_ready_tag = 1'b0;
  logic [127:0] I_tag = '0;
  logic         O_key_valid, O_valid_data, O_last_block, O_eot, O_busy, O_done, O_error;
  logic [127:0] O_data, O_tag;
  logic [4:0]   O_valid_bytes;
  logic [511:0] O_ct_buf;

  ascon_stream_sequencer dut (
    .crypto_clk(crypto_clk), .reset_i(reset_i), .I_start(I_start),
    .I_ad_len(I_ad_len), .I_msg_len(I_msg_len), .I_ad_buf(I_ad_buf), .I_msg_buf(I_msg_buf),
    .I_read_data(I_read_data), .I_ready_for_data(I_ready_for_data), .I_ct_valid(I_ct_valid),
    .I_ct(I_ct), .I_ready_tag(I_ready_tag), .I_tag(I_tag),
    .O_key_valid(O_key_valid), .O_data(O_data), .O_valid_data(O_valid_data),
    .O_last_block(O_last_block), .O_valid_bytes(O_valid_bytes), .O_eot(O_eot),
    .O_ct_buf(O_ct_buf), .O_tag(O_tag), .O_busy(O_busy), .O_done(O_done), .O_error(O_error)
  );

  always #5 crypto_clk = ~crypto_clk;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   vb;
    logic         last;
    logic         eot;
  } blk_t;

  typedef struct {
    logic         done;
    logic         err;
    logic [127:0] tag;
    logic [511:0] ct;
    int           busy_len;
  } res_t;

  blk_t exp_blk_q[$];
  res_t exp_res_q[$];
  int checks = 0;
  int errors = 0;
  logic [511:0] ad_buf, msg_buf, hold_ct;
  logic [127:0] hold_tag = '0;
  logic [127:0] model_tag = '0;
  bit model_read_en = 1'b1;
  int model_ct_limit = 4;
  bit prev_busy = 1'b0;
  bit start_rej = 1'b0;
  int busy_len = 0;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_blk(input bit is_msg, input int i, input int vb, input bit last);
    blk_t b;
    b.data = is_msg ? msg_buf[i*128 +: 128] : ad_buf[i*128 +: 128];
    b.vb   = 5'(vb);
    b.last = last;
    b.eot  = is_msg;
    exp_blk_q.push_back(b);
  endfunction

  function automatic logic [511:0] ct_of(input int n);
    logic [511:0] c = '0;
    for (int i = 0; i < n; i++) c[i*128 +: 128] = msg_buf[i*128 +: 128] ^ CT_MASK;
    return c;
  endfunction

  function automatic void push_res(input bit done, input bit err, input logic [511:0] ct,
                                   input bit tag_new, input int blen);
    res_t r;
    if (tag_new) hold_tag = model_tag;
    hold_ct    = ct;
    r.done     = done;
    r.err      = err;
    r.tag      = hold_tag;
    r.ct       = ct;
    r.busy_len = blen;
    exp_res_q.push_back(r);
  endfunction

  // Core model: accepts each block 5 cycles after it appears, returns ciphertext with MSG blocks.
  initial begin
    int wait_cnt = 0;
    int ct_sent = 0;
    int tag_wait = 0;
    forever begin
      @(posedge crypto_clk); #1;
      I_read_data = 1'b0;
      I_ct_valid  = 1'b0;
      if (reset_i || !O_busy) begin
        wait_cnt = 0; ct_sent = 0; tag_wait = 0;
        I_ready_tag = 1'b0;
      end else if (O_valid_data) begin
        if (model_read_en) begin
          wait_cnt++;
          if (wait_cnt == 5) begin
            wait_cnt = 0;
            I_read_data = 1'b1;
            if (O_eot && ct_sent < model_ct_limit) begin
              I_ct_valid = 1'b1;
              I_ct = O_data ^ CT_MASK;
              ct_sent++;
            end
          end
        end
      end else begin
        tag_wait++;
        if (tag_wait >= 3) begin
          I_ready_tag = 1'b1;
          I_tag = model_tag;
        end
      end
    end
  end

  // Monitor: compares each accepted block and each transaction outcome against the scoreboard.
  initial begin
    blk_t b;
    res_t r;
    forever begin
      @(negedge crypto_clk);
      if (!O_busy)
        chk("idle_strobes", 512'({O_key_valid, O_valid_data, O_last_block, O_eot, O_valid_bytes, O_data}), 512'd0);
      if (O_valid_data && I_read_data) begin
        if (exp_blk_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL blk_unexpected: got block %0h expected none", O_data);
        end else begin
          b = exp_blk_q.pop_front();
          chk("blk_data", 512'(O_data), 512'(b.data));
          chk("blk_vb", 512'(O_valid_bytes), 512'(b.vb));
          chk("blk_last", 512'(O_last_block), 512'(b.last));
          chk("blk_eot", 512'(O_eot), 512'(b.eot));
          chk("blk_key", 512'(O_key_valid), 512'd1);
        end
      end
      if ((prev_busy && !O_busy) || (start_rej && !O_busy)) begin
        if (exp_res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected: got done=%0d error=%0d expected no completion", O_done, O_error);
        end else begin
          r = exp_res_q.pop_front();
          chk("res_done", 512'(O_done), 512'(r.done));
          chk("res_error", 512'(O_error), 512'(r.err));
          chk("res_tag", 512'(O_tag), 512'(r.tag));
          chk("res_ct", O_ct_buf, r.ct);
          if (r.busy_len > 0) chk("res_busy_len", 512'(busy_len), 512'(r.busy_len));
        end
      end
      if (O_busy) busy_len = prev_busy ? busy_len + 1 : 1;
      start_rej = I_start && !O_busy;
      prev_busy = O_busy;
    end
  end

  task automatic start_txn(input int ad_len, input int msg_len, input int n);
    model_tag = {96'h7A61_7461_6774_6167_0000_0000, 32'(n)};
    @(posedge crypto_clk); #1;
    I_ad_len  = 7'(ad_len);
    I_msg_len = 7'(msg_len);
    I_start   = 1'b1;
    @(posedge crypto_clk); #1;
    I_start   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_res_q.size() != 0 && n < 6000) begin
      @(posedge crypto_clk);
      n++;
    end
    if (exp_res_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: result not seen within %0d cycles", name, n);
      exp_res_q.delete();
    end
    chk({name, "_blk_left"}, 512'(exp_blk_q.size()), 512'd0);
    exp_blk_q.delete();
    repeat (3) @(posedge crypto_clk);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    ad_buf  = {128'hAD03_0303_1313_1313_2323_2323_3333_3333, 128'hAD02_0202_1212_1212_2222_2222_3232_3232,
               128'hAD01_0101_1111_1111_2121_2121_3131_3131, 128'hAD00_0000_1010_1010_2020_2020_3030_3030};
    msg_buf = {128'h5E03_C0DE_4444_5555_6666_7777_8888_9993, 128'h5E02_C0DE_4444_5555_6666_7777_8888_9992,
               128'h5E01_C0DE_4444_5555_6666_7777_8888_9991, 128'h5E00_C0DE_4444_5555_6666_7777_8888_9990};
    hold_ct   = '0;
    I_ad_buf  = ad_buf;
    I_msg_buf = msg_buf;
    repeat (3) @(posedge crypto_clk);
    #1 reset_i = 1'b0;
    @(negedge crypto_clk);
    chk("rst_busy", 512'(O_busy), 512'd0);
    chk("rst_error", 512'(O_error), 512'd0);
    chk("rst_done", 512'(O_done), 512'd0);
    chk("rst_tag", 512'(O_tag), 512'd0);
    chk("rst_ct", O_ct_buf, 512'd0);

    // single block each phase
    push_blk(0, 0, 16, 1); push_blk(1, 0, 16, 1);
    model_tag = {96'h7A61_7461_6774_6167_0000_0000, 32'd1};
    push_res(1, 0, ct_of(1), 1, 0);
    start_txn(16, 16, 1);
    wait_drain("t1_16_16");

    // empty AD, partial final MSG block
    push_blk(0, 0, 0, 1);
    push_blk(1, 0, 16, 0); push_blk(1, 1, 16, 0); push_blk(1, 2, 5, 1);
    model_tag = {96'h7A61_7461_6774_6167_0000_0000, 32'd2};
    push_res(1, 0, ct_of(3), 1, 0);
    start_txn(0, 37, 2);
    wait_drain("t2_0_37");

    // four AD blocks with 2-byte tail, full-size MSG; a start while busy must be ignored
    push_blk(0, 0, 16, 0); push_blk(0, 1, 16, 0); push_blk(0, 2, 16, 0); push_blk(0, 3, 2, 1);
    push_blk(1, 0, 16, 0); push_blk(1, 1, 16, 0); push_blk(1, 2, 16, 0); push_blk(1, 3, 16, 1);
    model_tag = {96'h7A61_7461_6774_6167_0000_0000, 32'd3};
    push_res(1, 0, ct_of(4), 1, 0);
    start_txn(50, 64, 3);
    repeat (4) @(posedge crypto_clk);
    #1 I_ad_len = 7'd100; I_start = 1'b1;
    @(posedge crypto_clk); #1 I_start = 1'b0;
    wait_drain("t3_50_64");

    // oversize AD length is rejected; captured results are left untouched
    push_res(0, 1, hold_ct, 0, 0);
    start_txn(65, 16, 4);
    wait_drain("t4_reject");

    // only one ciphertext block for a two-block message
    model_ct_limit = 1;
    push_blk(0, 0, 16, 1); push_blk(1, 0, 16, 0); push_blk(1, 1, 16, 1);
    model_tag = {96'h7A61_7461_6774_6167_0000_0000, 32'd5};
    push_res(0, 1, ct_of(1), 1, 0);
    start_txn(16, 32, 5);
    wait_drain("t5_ct_short");
    model_ct_limit = 4;

    // core never consumes: watchdog aborts after TO busy cycles
    model_read_en = 1'b0;
    push_res(0, 1, 512'd0, 0, TO);
    start_txn(16, 16, 6);
    wait_drain("t6_timeout");
    model_read_en = 1'b1;

    // reset during MSG phase
    push_blk(0, 0, 16, 1); push_blk(1, 0, 16, 0); push_blk(1, 1, 16, 0); push_blk(1, 2, 16, 1);
    start_txn(16, 48, 7);
    begin
      int n = 0;
      do begin
        @(negedge crypto_clk);
        n++;
      end while (!(O_eot && I_read_data) && n < 200);
      chk("t7_reached_msg", 512'(O_eot && I_read_data), 512'd1);
    end
    @(posedge crypto_clk); #1;
    reset_i = 1'b1;
    exp_blk_q.delete();
    hold_tag = '0;
    push_res(0, 0, 512'd0, 0, 0);
    @(posedge crypto_clk); #1 reset_i = 1'b0;
    wait_drain("t7_reset");

    // clean transaction after reset
    push_blk(0, 0, 16, 0); push_blk(0, 1, 4, 1); push_blk(1, 0, 3, 1);
    model_tag = {96'h7A61_7461_6774_6167_0000_0000, 32'd8};
    push_res(1, 0, ct_of(1), 1, 0);
    start_txn(20, 3, 8);
    wait_drain("t8_after_reset");

    repeat (5) @(posedge crypto_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
